dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter n, default 32, SHALL set the data and address width.
REQ-002 Parameter DEPTH, default 64, SHALL set the number of n-bit words; power of two, >= 2.
REQ-003 Parameter LAT, default 2, SHALL set the access wait cycles; >= 1.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port memread, input, 1, load request from the controller.
REQ-008 Port memwrite, input, 1, store request from the controller.
REQ-009 Port addr, input, n, byte address; this is the datapath aluout.
REQ-010 Port wdata, input, n, store data; this is the datapath writedata.
REQ-011 Port readdata, output, n, load result to the datapath result mux and pc mux.
REQ-012 Port stall, output, 1, freezes the PC and register write while high.
REQ-013 Port err, output, 1, sticky fault flag.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-015 A request is valid in IDLE when (memread | memwrite) and addr[1:0] == 0.
REQ-016 On a valid request, the edge SHALL latch the word index, wdata and operation type, load the counter with LAT-1, and move to WAIT.
REQ-017 WAIT with counter == 0 SHALL move to DONE; otherwise the counter SHALL decrement.
REQ-018 DONE SHALL move to IDLE unconditionally.
REQ-019 stall SHALL be combinational: high in IDLE with a valid request and high in WAIT; low otherwise.
- Result: exactly LAT+1 stall cycles per access, then one DONE cycle with stall low.
REQ-020 The WAIT->DONE edge SHALL write the array for a store and SHALL register the array word into readdata for a load.
REQ-021 readdata SHALL hold its value until the next load completes; stores and idle cycles SHALL not change it.
REQ-022 Inputs SHALL be ignored in WAIT and DONE.
- The latched request is used.
- A request present in DONE is not re-accepted until the following IDLE cycle.
REQ-023 Word index SHALL be addr[log2(DEPTH)+1:2].
- Higher address bits are ignored, so accesses wrap modulo DEPTH.
REQ-024 A misaligned request (addr[1:0] != 0 with memread | memwrite) in IDLE SHALL:
- cause no access and no stall;
- set err at the edge.
REQ-025 memread and memwrite both high in IDLE SHALL be performed as a store, and SHALL set err.
REQ-026 err SHALL remain set until reset.

Reset
REQ-027 Reset SHALL force, immediately and independent of clk:
- state = IDLE, counter = 0, readdata = 0, err = 0, stall = 0;
- a write pending in WAIT is dropped.
REQ-028 Reset SHALL NOT clear array contents.
REQ-029 After reset deasserts, the first rising edge SHALL evaluate requests as IDLE.

Structure
REQ-030 Package dmem_pkg SHALL hold:
- the state enum type;
- default constants for DEPTH and LAT;
- the alignment-mask constant.
REQ-031 Sub-module dmem_array SHALL implement the DEPTH x n storage:
- synchronous write-enable port;
- asynchronous read port.
REQ-032 dmem_ctrl SHALL contain the FSM, counter, latches, readdata register and err logic.
- The counter width is $clog2(LAT)+1.

Verification (n=32, DEPTH=64, LAT=2)
REQ-033 Store:
- Stimulus: memwrite=1, addr=0x10, wdata=0xDEADBEEF.
- Response: stall high 3 cycles, low in the 4th; word 4 = 0xDEADBEEF; readdata unchanged.
REQ-034 Load:
- Stimulus: memread=1, addr=0x10 after REQ-033.
- Response: stall high 3 cycles; readdata = 0xDEADBEEF in the DONE cycle, held afterwards.
REQ-035 Wrap:
- Stimulus: store 0x12345678 at addr=0x110.
- Response: load from addr=0x10 returns 0x12345678.
REQ-036 Misaligned:
- Stimulus: memread=1, addr=0x13.
- Response: stall never high; err=1 after the edge; readdata unchanged; err still 1 after 10 idle cycles.
REQ-037 Reset mid-store:
- Stimulus: assert reset during the WAIT of a store of 0xCAFEF00D to addr=0x20 (prior word 8 = 0x1).
- Response: stall=0 and readdata=0 immediately; after release, a load from 0x20 returns 0x1.
REQ-038 Conflict plus back-to-back:
- Stimulus: memread=memwrite=1, addr=0x8, wdata=0xA5A5A5A5, then a load of 0x8 presented in DONE.
- Response: store performed, err=1; the load starts only in the next IDLE cycle and returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory controller
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_DEPTH = 64;
   localparam int DEFAULT_LAT   = 2;

   // Byte-offset bits that must be zero for a legal word access.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [1:0] lo);
      return (lo & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - controller-side data memory bus
interface dmem_if #(
   parameter int n = 32
);
   logic         memread;
   logic         memwrite;
   logic [n-1:0] addr;
   logic [n-1:0] wdata;
   logic [n-1:0] readdata;
   logic         stall;
   logic         err;

   modport master (
      output memread, memwrite, addr, wdata,
      input  readdata, stall, err
   );

   modport slave (
      input  memread, memwrite, addr, wdata,
      output readdata, stall, err
   );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x n storage, synchronous write, asynchronous read
module dmem_array #(
   parameter int n     = 32,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [n-1:0]             wdata,
   output logic [n-1:0]             rdata
);
   logic [n-1:0] mem [DEPTH];

   // No reset: contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle data memory controller with stall and sticky error
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int n     = 32,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int LAT   = DEFAULT_LAT
) (
   input  logic clk,
   input  logic reset,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LAT) + 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [n-1:0]   wdata_q, wdata_d;
   logic           wr_q, wr_d;
   logic [n-1:0]   readdata_q, readdata_d;
   logic           err_q, err_d;

   logic           req;
   logic           in_idle;
   logic           valid_req;
   logic           misalign;
   logic           conflict;
   logic           finish;
   logic           arr_we;
   logic [n-1:0]   arr_rdata;

   // Address bits above the word index are intentionally ignored (wrap).
   logic           unused_addr_bits;
   assign unused_addr_bits = ^bus.addr[n-1:AW+2];

   dmem_array #(
      .n     (n),
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   always_comb begin
      req       = bus.memread | bus.memwrite;
      in_idle   = (state_q == IDLE);
      valid_req = in_idle && req && is_aligned(bus.addr[1:0]);
      misalign  = in_idle && req && !is_aligned(bus.addr[1:0]);
      conflict  = in_idle && bus.memread && bus.memwrite;
      finish    = (state_q == WAIT) && (cnt_q == '0);
      arr_we    = finish && wr_q;

      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      readdata_d = readdata_q;
      err_d      = err_q | misalign | conflict;

      case (state_q)
         IDLE: begin
            if (valid_req) begin
               state_d = WAIT;
               cnt_d   = CW'(LAT - 1);
               idx_d   = bus.addr[AW+1:2];
               wdata_d = bus.wdata;
               wr_d    = bus.memwrite;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!wr_q) begin
                  readdata_d = arr_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         readdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         wr_q       <= wr_d;
         readdata_q <= readdata_d;
         err_q      <= err_d;
      end
   end

   // Stall goes high in the request cycle itself so the PC freezes at once.
   assign bus.stall    = valid_req || (state_q == WAIT);
   assign bus.readdata = readdata_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   dmem_if #(.n(32)) bus ();

   dmem_ctrl #(
      .n     (32),
      .DEPTH (64),
      .LAT   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request at a negedge and follows it to its DONE cycle.
   // Returns the number of stall-high cycles observed; leaves time at DONE+1ns.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int n_stall);
      @(negedge clk);
      bus.memread  = rd;
      bus.memwrite = wr;
      bus.addr     = a;
      bus.wdata    = d;
      #1;
      n_stall = 0;
      while (bus.stall && n_stall < 20) begin
         n_stall++;
         @(posedge clk);
         #1;
         bus.memread  = 1'b0;
         bus.memwrite = 1'b0;
         @(negedge clk);
         #1;
      end
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic test_reset;
      reset        = 1'b1;
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stall got %b want 0", bus.stall);
      end
      tests_run++;
      if (bus.readdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_readdata got %h want 00000000", bus.readdata);
      end
      tests_run++;
      if (bus.err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_err got %b want 0", bus.err);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_store;
      int ns;
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns);
      tests_run++;
      if (ns !== 3) begin
         tests_failed++;
         $display("FAIL store_stall_cycles got %0d want 3", ns);
      end
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL store_done_stall got %b want 0", bus.stall);
      end
      tests_run++;
      if (bus.readdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL store_readdata got %h want 00000000", bus.readdata);
      end
      idle(2);
   endtask

   task automatic test_load;
      int ns;
      access(1'b1, 1'b0, 32'h10, 32'h0, ns);
      tests_run++;
      if (ns !== 3) begin
         tests_failed++;
         $display("FAIL load_stall_cycles got %0d want 3", ns);
      end
      tests_run++;
      if (bus.readdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL load_done_readdata got %h want deadbeef", bus.readdata);
      end
      idle(3);
      #1;
      tests_run++;
      if (bus.readdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL load_hold_readdata got %h want deadbeef", bus.readdata);
      end
   endtask

   task automatic test_wrap;
      int ns;
      access(1'b0, 1'b1, 32'h110, 32'h12345678, ns);
      tests_run++;
      if (bus.readdata !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL wrap_store_readdata got %h want deadbeef", bus.readdata);
      end
      idle(1);
      access(1'b1, 1'b0, 32'h10, 32'h0, ns);
      tests_run++;
      if (bus.readdata !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL wrap_load got %h want 12345678", bus.readdata);
      end
      idle(1);
   endtask

   task automatic test_misaligned;
      int hi;
      hi = 0;
      @(negedge clk);
      bus.memread = 1'b1;
      bus.addr    = 32'h13;
      #1;
      if (bus.stall) hi++;
      @(posedge clk);
      #1;
      bus.memread = 1'b0;
      tests_run++;
      if (bus.err !== 1'b1) begin
         tests_failed++;
         $display("FAIL misalign_err got %b want 1", bus.err);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (bus.stall) hi++;
      end
      tests_run++;
      if (hi !== 0) begin
         tests_failed++;
         $display("FAIL misalign_stall got %0d high cycles want 0", hi);
      end
      tests_run++;
      if (bus.readdata !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL misalign_readdata got %h want 12345678", bus.readdata);
      end
      tests_run++;
      if (bus.err !== 1'b1) begin
         tests_failed++;
         $display("FAIL misalign_err_sticky got %b want 1", bus.err);
      end
   endtask

   task automatic test_reset_mid_store;
      int ns;
      access(1'b0, 1'b1, 32'h20, 32'h1, ns);
      idle(1);
      @(negedge clk);
      bus.memwrite = 1'b1;
      bus.addr     = 32'h20;
      bus.wdata    = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      bus.memwrite = 1'b0;
      tests_run++;
      if (bus.stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_wait_stall got %b want 1", bus.stall);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_stall got %b want 0", bus.stall);
      end
      tests_run++;
      if (bus.readdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_mid_readdata got %h want 00000000", bus.readdata);
      end
      tests_run++;
      if (bus.err !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_err got %b want 0", bus.err);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      access(1'b1, 1'b0, 32'h20, 32'h0, ns);
      tests_run++;
      if (bus.readdata !== 32'h1) begin
         tests_failed++;
         $display("FAIL rst_mid_load got %h want 00000001", bus.readdata);
      end
      idle(1);
   endtask

   task automatic test_back_to_back;
      int ns;
      access(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, ns);
      tests_run++;
      if (ns !== 3) begin
         tests_failed++;
         $display("FAIL conflict_stall_cycles got %0d want 3", ns);
      end
      tests_run++;
      if (bus.err !== 1'b1) begin
         tests_failed++;
         $display("FAIL conflict_err got %b want 1", bus.err);
      end
      tests_run++;
      if (bus.readdata !== 32'h1) begin
         tests_failed++;
         $display("FAIL conflict_readdata got %h want 00000001", bus.readdata);
      end
      // Present the load while the controller is in DONE.
      bus.memread = 1'b1;
      bus.addr    = 32'h8;
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_done_stall got %b want 0", bus.stall);
      end
      ns = 0;
      @(negedge clk);
      #1;
      while (bus.stall && ns < 20) begin
         ns++;
         @(posedge clk);
         #1;
         bus.memread = 1'b0;
         @(negedge clk);
         #1;
      end
      bus.memread = 1'b0;
      tests_run++;
      if (ns !== 3) begin
         tests_failed++;
         $display("FAIL b2b_stall_cycles got %0d want 3", ns);
      end
      tests_run++;
      if (bus.readdata !== 32'hA5A5A5A5) begin
         tests_failed++;
         $display("FAIL b2b_load got %h want a5a5a5a5", bus.readdata);
      end
      idle(1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_store();
      test_load();
      test_wrap();
      test_misaligned();
      test_reset_mid_store();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
